// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus width defaults, arbiter state encoding and a
// counter-width helper used by the memory-port arbiter.
package cpu_pkg;

  // Default address/data widths shared by the core, arbiter and memory model.
  localparam int unsigned CPU_AW = 32;
  localparam int unsigned CPU_DW = 32;

  // Memory-port arbiter ownership states.
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_I,
    ARB_BUSY_D
  } arb_state_e;

  // Bits needed to hold 0..maxval; never returns 0 so a disabled feature
  // (maxval == 0) still yields a legal one-bit vector.
  function automatic int unsigned cnt_width(input int unsigned maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-port signals around the arbiter.
// slave: the arbiter's view. master: the surrounding core/memory view.
interface mem_arbiter_if
  import cpu_pkg::*;
#(
  parameter int unsigned AW = CPU_AW,
  parameter int unsigned DW = CPU_DW
) ();

  // Instruction-fetch requester
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          i_err;

  // Load/store requester
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          d_err;

  // Unified memory port
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport slave (
    input  i_req, i_addr,
    output i_ack, i_rdata, i_err,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_rdata, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport master (
    output i_req, i_addr,
    input  i_ack, i_rdata, i_err,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_arbiter.sv
// Shares the single memory port between instruction fetch (I) and load/store
// (D). D wins by default; after STARVE_LIMIT consecutive D grants while I is
// waiting, I is granted. A watchdog aborts a transaction the memory never
// acknowledges and returns an error response to the owner.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned AW           = CPU_AW,
  parameter int unsigned DW           = CPU_DW,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned SW = cnt_width(STARVE_LIMIT);
  localparam int unsigned TW = cnt_width(TIMEOUT);

  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
  // Last timer value before abort; unused when the watchdog is disabled.
  localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
  localparam logic [DW-1:0] RDATA_ERR  = '0;

  arb_state_e    state;
  logic [SW-1:0] streak;  // consecutive D grants while I was waiting
  logic [TW-1:0] timer;   // cycles spent in the current transaction

  logic          busy;
  logic          timeout;
  logic          done;
  logic          grant_d;
  logic          grant_i;
  logic [AW-1:0] grant_addr;
  logic [SW-1:0] streak_inc;

  // Arbitration decision, watchdog expiry and transaction completion.
  always_comb begin
    busy    = (state != ARB_IDLE);
    // A coincident mem_ack wins over the watchdog.
    timeout = (TIMEOUT != 0) && busy && !bus.mem_ack && (timer == TIMER_LAST);
    done    = busy && (bus.mem_ack || timeout);

    grant_d = (state == ARB_IDLE) && bus.d_req && (!bus.i_req || (streak < STREAK_MAX));
    grant_i = (state == ARB_IDLE) && !grant_d && bus.i_req;

    grant_addr = grant_d ? bus.d_addr : bus.i_addr;
    streak_inc = (streak == STREAK_MAX) ? streak : streak + 1'b1;
  end

  // Responses follow mem_ack combinationally; a watchdog abort forces rdata to 0.
  always_comb begin
    bus.i_ack   = done && (state == ARB_BUSY_I);
    bus.i_err   = timeout && (state == ARB_BUSY_I);
    bus.i_rdata = (timeout && (state == ARB_BUSY_I)) ? RDATA_ERR : bus.mem_rdata;

    bus.d_ack   = done && (state == ARB_BUSY_D);
    bus.d_err   = timeout && (state == ARB_BUSY_D);
    bus.d_rdata = (timeout && (state == ARB_BUSY_D)) ? RDATA_ERR : bus.mem_rdata;
  end

  // Ownership FSM with registered memory-port outputs, streak and watchdog.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ARB_IDLE;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      streak        <= '0;
      timer         <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (grant_d) begin
            state         <= ARB_BUSY_D;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.d_we;
            bus.mem_addr  <= grant_addr;
            bus.mem_wdata <= bus.d_wdata;
            timer         <= '0;
            // Streak only counts D grants that made I wait.
            streak        <= bus.i_req ? streak_inc : '0;
          end else if (grant_i) begin
            state        <= ARB_BUSY_I;
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= grant_addr;
            timer        <= '0;
            streak       <= '0;
          end
        end
        ARB_BUSY_I, ARB_BUSY_D: begin
          if (done) begin
            state       <= ARB_IDLE;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state       <= ARB_IDLE;
          bus.mem_req <= 1'b0;
          bus.mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int SL = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(
    .AW          (AW),
    .DW          (DW),
    .STARVE_LIMIT(SL),
    .TIMEOUT     (TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port, how long, and what was latched.
  int            m_own = 0;     // 0 none, 1 fetch, 2 data
  int            m_streak = 0;  // D grants in a row while I waited
  int            m_age = 0;     // cycles the owner has been waiting
  logic [AW-1:0] m_addr = '0;
  logic          m_we = 1'b0;
  logic [DW-1:0] m_wdata = '0;

  int exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  int lats[6] = '{0, 1, 2, 3, 7, 12};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_in();
    rst           = 1'b1;
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  // Compare all DUT outputs with the model, then advance the model one clock.
  task automatic check();
    logic tmo;
    logic i_own;
    logic d_own;
    #1;
    tmo   = (m_own != 0) && !bus.mem_ack && (m_age == TO - 1);
    i_own = (m_own == 1);
    d_own = (m_own == 2);
    chk("mem_req", bus.mem_req, m_own != 0);
    chk("mem_we", bus.mem_we, m_we);
    chk("mem_addr", bus.mem_addr, m_addr);
    chk("mem_wdata", bus.mem_wdata, m_wdata);
    chk("i_ack", bus.i_ack, i_own && (bus.mem_ack || tmo));
    chk("i_err", bus.i_err, i_own && tmo);
    chk("i_rdata", bus.i_rdata, (i_own && tmo) ? 32'h0 : bus.mem_rdata);
    chk("d_ack", bus.d_ack, d_own && (bus.mem_ack || tmo));
    chk("d_err", bus.d_err, d_own && tmo);
    chk("d_rdata", bus.d_rdata, (d_own && tmo) ? 32'h0 : bus.mem_rdata);

    if (!rst) begin
      m_own = 0; m_streak = 0; m_age = 0;
      m_addr = '0; m_we = 1'b0; m_wdata = '0;
    end else if (m_own != 0) begin
      if (bus.mem_ack || tmo) begin
        m_own = 0;
        m_we  = 1'b0;
      end else begin
        m_age++;
      end
    end else if (bus.d_req && (!bus.i_req || m_streak < SL)) begin
      m_own    = 2;
      m_age    = 0;
      m_streak = bus.i_req ? ((m_streak < SL) ? m_streak + 1 : SL) : 0;
      m_addr   = bus.d_addr;
      m_we     = bus.d_we;
      m_wdata  = bus.d_wdata;
    end else if (bus.i_req) begin
      m_own    = 1;
      m_age    = 0;
      m_streak = 0;
      m_addr   = bus.i_addr;
      m_we     = 1'b0;
    end
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin
      tick();
      idle_in();
      rst = 1'b0;
      check();
    end
  endtask

  initial begin
    int got[$];
    int mem_cyc;
    int lat;
    logic i_acked;
    logic d_acked;

    idle_in();
    rst = 1'b0;

    // Reset state
    do_reset();
    tick(); idle_in(); check();
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);

    // Single fetch, memory acks two cycles after mem_req
    do_reset();
    tick(); idle_in(); bus.i_req = 1'b1; bus.i_addr = 32'h100; check();
    tick(); check();
    chk("t1_mem_req", bus.mem_req, 1'b1);
    chk("t1_mem_addr", bus.mem_addr, 32'h100);
    chk("t1_mem_we", bus.mem_we, 1'b0);
    tick(); check();
    chk("t1_no_ack_early", bus.i_ack, 1'b0);
    tick(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF; check();
    chk("t1_i_ack", bus.i_ack, 1'b1);
    chk("t1_i_rdata", bus.i_rdata, 32'hDEADBEEF);
    tick(); idle_in(); check();
    chk("t1_mem_req_drop", bus.mem_req, 1'b0);

    // Data write acknowledged in the first mem_req cycle
    do_reset();
    tick(); idle_in();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'h55;
    check();
    tick(); bus.mem_ack = 1'b1; check();
    chk("t2_mem_we", bus.mem_we, 1'b1);
    chk("t2_mem_wdata", bus.mem_wdata, 32'h55);
    chk("t2_d_ack", bus.d_ack, 1'b1);
    chk("t2_d_err", bus.d_err, 1'b0);
    tick(); idle_in(); check();

    // Both requesters held: starvation guard lets I in after four D grants
    do_reset();
    for (int c = 0; c < 60 && got.size() < 10; c++) begin
      tick(); idle_in();
      bus.i_req = 1'b1; bus.i_addr = 32'h100;
      bus.d_req = 1'b1; bus.d_addr = 32'h200;
      bus.mem_ack = bus.mem_req;
      bus.mem_rdata = $urandom;
      check();
      if (bus.mem_req && bus.mem_ack) got.push_back((bus.mem_addr == 32'h200) ? 1 : 0);
    end
    chk("t3_grant_count", got.size(), 10);
    for (int k = 0; k < got.size() && k < 10; k++)
      chk($sformatf("t3_grant%0d_is_d", k), got[k], exp_order[k]);

    // Watchdog abort on a silent memory, then the waiting fetch proceeds
    do_reset();
    tick(); idle_in();
    bus.d_req = 1'b1; bus.d_addr = 32'h40; bus.i_req = 1'b1; bus.i_addr = 32'h180;
    check();
    for (int k = 1; k <= 8; k++) begin
      tick(); bus.mem_rdata = 32'hFFFF0000; check();
      if (k < 8) begin
        chk($sformatf("t4_wait%0d_d_ack", k), bus.d_ack, 1'b0);
      end else begin
        chk("t4_d_ack", bus.d_ack, 1'b1);
        chk("t4_d_err", bus.d_err, 1'b1);
        chk("t4_d_rdata", bus.d_rdata, 32'h0);
      end
    end
    tick(); bus.d_req = 1'b0; check();
    chk("t4_idle", bus.mem_req, 1'b0);
    tick(); bus.mem_ack = 1'b1; check();
    chk("t4_i_mem_req", bus.mem_req, 1'b1);
    chk("t4_i_addr", bus.mem_addr, 32'h180);
    chk("t4_i_ack", bus.i_ack, 1'b1);
    chk("t4_i_err", bus.i_err, 1'b0);
    tick(); idle_in(); check();

    // Reset while a data access is outstanding
    do_reset();
    tick(); idle_in(); bus.d_req = 1'b1; bus.d_addr = 32'h60; check();
    tick(); check();
    chk("t5_busy", bus.mem_req, 1'b1);
    tick(); rst = 1'b0; check();
    chk("t5_no_ack_in_rst", bus.d_ack, 1'b0);
    tick(); idle_in(); bus.mem_ack = 1'b1; check();
    chk("t5_mem_req", bus.mem_req, 1'b0);
    chk("t5_stray_d_ack", bus.d_ack, 1'b0);
    chk("t5_stray_i_ack", bus.i_ack, 1'b0);

    // mem_ack on the watchdog cycle is a normal completion
    do_reset();
    tick(); idle_in(); bus.d_req = 1'b1; bus.d_addr = 32'h80; check();
    for (int k = 1; k <= 8; k++) begin
      tick();
      bus.mem_ack = (k == 8);
      bus.mem_rdata = 32'h12345678;
      check();
    end
    chk("t6_d_ack", bus.d_ack, 1'b1);
    chk("t6_d_err", bus.d_err, 1'b0);
    chk("t6_d_rdata", bus.d_rdata, 32'h12345678);
    tick(); idle_in(); check();

    // Random traffic against the model
    do_reset();
    i_acked = 1'b0;
    d_acked = 1'b0;
    mem_cyc = 0;
    lat = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 199) != 0);
      if (i_acked || !bus.i_req) begin
        bus.i_req  = ($urandom_range(0, 2) != 0);
        bus.i_addr = $urandom;
      end
      if (d_acked || !bus.d_req) begin
        bus.d_req   = ($urandom_range(0, 2) != 0);
        bus.d_we    = $urandom_range(0, 1);
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
      end
      bus.mem_rdata = $urandom;
      if (bus.mem_req) begin
        if (mem_cyc == 0) lat = lats[$urandom_range(0, 5)];
        bus.mem_ack = (mem_cyc == lat);
        mem_cyc++;
      end else begin
        mem_cyc = 0;
        bus.mem_ack = ($urandom_range(0, 9) == 0);
      end
      check();
      i_acked = bus.i_ack;
      d_acked = bus.d_ack;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
